// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: default widths, latency, starvation limit and
// owner encodings.
package dmem_arbiter_pkg;

  localparam int unsigned DMEM_ADDR_W     = 24;
  localparam int unsigned DMEM_DATA_W     = 24;
  localparam int unsigned DMEM_MEM_LAT    = 2;
  localparam int unsigned DMEM_STARVE_MAX = 4;

  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_AUX  = 1'b1;

endpackage

// File: rtl/dmem_arb_select.sv
// Winner selection between core and aux: core has priority unless aux has waited through
// STARVE_MAX consecutive core grants.
module dmem_arb_select
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = DMEM_STARVE_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic eligible,
  input  logic core_req,
  input  logic aux_req,
  output logic core_gnt,
  output logic aux_gnt
);

  logic [3:0] starve_q;
  logic       starved;

  always_comb begin
    starved  = (starve_q == 4'(STARVE_MAX));
    aux_gnt  = !rst && eligible && aux_req && (!core_req || starved);
    core_gnt = !rst && eligible && core_req && !aux_gnt;
  end

  // Counts core grants that aux sat through; any break in aux waiting restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else if (aux_gnt || !aux_req) begin
      starve_q <= '0;
    end else if (core_gnt && !starved) begin
      starve_q <= starve_q + 4'd1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one fixed-latency data-memory port between the core MEM stage and an aux requester,
// tracking the in-flight read and routing its data back to the owner.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = DMEM_ADDR_W,
  parameter int unsigned DATA_W     = DMEM_DATA_W,
  parameter int unsigned MEM_LAT    = DMEM_MEM_LAT,
  parameter int unsigned STARVE_MAX = DMEM_STARVE_MAX
) (
  input  logic              iw_clk,
  input  logic              iw_rst,
  input  logic              iw_core_req,
  input  logic              iw_core_we,
  input  logic [ADDR_W-1:0] iw_core_addr,
  input  logic [DATA_W-1:0] iw_core_wdata,
  output logic              ow_core_gnt,
  output logic              ow_core_rvalid,
  output logic [DATA_W-1:0] ow_core_rdata,
  input  logic              iw_aux_req,
  input  logic              iw_aux_we,
  input  logic [ADDR_W-1:0] iw_aux_addr,
  input  logic [DATA_W-1:0] iw_aux_wdata,
  output logic              ow_aux_gnt,
  output logic              ow_aux_rvalid,
  output logic [DATA_W-1:0] ow_aux_rdata,
  output logic              ow_mem_en,
  output logic              ow_mem_we,
  output logic [ADDR_W-1:0] ow_mem_addr,
  output logic [DATA_W-1:0] ow_mem_wdata,
  input  logic [DATA_W-1:0] iw_mem_rdata,
  output logic              ow_busy
);

  logic [2:0] cnt_q;
  logic       own_q;
  logic       eligible;
  logic       core_gnt;
  logic       aux_gnt;
  logic       gnt;
  logic       sel_we;
  logic       rvalid;

  // A new issue may overlap the cycle in which the previous read returns.
  assign eligible = (cnt_q <= 3'd1);

  dmem_arb_select #(
    .STARVE_MAX(STARVE_MAX)
  ) u_select (
    .clk     (iw_clk),
    .rst     (iw_rst),
    .eligible(eligible),
    .core_req(iw_core_req),
    .aux_req (iw_aux_req),
    .core_gnt(core_gnt),
    .aux_gnt (aux_gnt)
  );

  always_comb begin
    gnt            = core_gnt | aux_gnt;
    sel_we         = aux_gnt ? iw_aux_we : iw_core_we;
    ow_core_gnt    = core_gnt;
    ow_aux_gnt     = aux_gnt;
    ow_mem_en      = gnt;
    ow_mem_we      = gnt & sel_we;
    ow_mem_addr    = aux_gnt ? iw_aux_addr  : (core_gnt ? iw_core_addr  : '0);
    ow_mem_wdata   = aux_gnt ? iw_aux_wdata : (core_gnt ? iw_core_wdata : '0);
    rvalid         = !iw_rst && (cnt_q == 3'd1);
    ow_core_rvalid = rvalid && (own_q == OWN_CORE);
    ow_aux_rvalid  = rvalid && (own_q == OWN_AUX);
    ow_core_rdata  = ow_core_rvalid ? iw_mem_rdata : '0;
    ow_aux_rdata   = ow_aux_rvalid  ? iw_mem_rdata : '0;
    ow_busy        = !iw_rst && (cnt_q != 3'd0);
  end

  // Writes leave the counter alone so an earlier read still completes on schedule.
  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      cnt_q <= '0;
      own_q <= OWN_CORE;
    end else if (gnt && !sel_we) begin
      cnt_q <= 3'(MEM_LAT);
      own_q <= aux_gnt ? OWN_AUX : OWN_CORE;
    end else if (cnt_q != 3'd0) begin
      cnt_q <= cnt_q - 3'd1;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: three instances (MEM_LAT 1, 2, 3) share stimulus; a cycle
// table drives the MEM_LAT=2 instance, hand sequences cover latency-1 streaming and mid-read reset.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_we, aux_req, aux_we;
  logic [23:0] core_addr, core_wdata, aux_addr, aux_wdata, mem_rdata;

  logic        core_gnt   [1:3];
  logic        core_rvalid[1:3];
  logic [23:0] core_rdata [1:3];
  logic        aux_gnt    [1:3];
  logic        aux_rvalid [1:3];
  logic [23:0] aux_rdata  [1:3];
  logic        mem_en     [1:3];
  logic        mem_we     [1:3];
  logic [23:0] mem_addr   [1:3];
  logic [23:0] mem_wdata  [1:3];
  logic        busy       [1:3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar k = 1; k <= 3; k++) begin : g_dut
    dmem_arbiter #(
      .ADDR_W    (24),
      .DATA_W    (24),
      .MEM_LAT   (k),
      .STARVE_MAX(4)
    ) u_dut (
      .iw_clk        (clk),
      .iw_rst        (rst),
      .iw_core_req   (core_req),
      .iw_core_we    (core_we),
      .iw_core_addr  (core_addr),
      .iw_core_wdata (core_wdata),
      .ow_core_gnt   (core_gnt[k]),
      .ow_core_rvalid(core_rvalid[k]),
      .ow_core_rdata (core_rdata[k]),
      .iw_aux_req    (aux_req),
      .iw_aux_we     (aux_we),
      .iw_aux_addr   (aux_addr),
      .iw_aux_wdata  (aux_wdata),
      .ow_aux_gnt    (aux_gnt[k]),
      .ow_aux_rvalid (aux_rvalid[k]),
      .ow_aux_rdata  (aux_rdata[k]),
      .ow_mem_en     (mem_en[k]),
      .ow_mem_we     (mem_we[k]),
      .ow_mem_addr   (mem_addr[k]),
      .ow_mem_wdata  (mem_wdata[k]),
      .iw_mem_rdata  (mem_rdata),
      .ow_busy       (busy[k])
    );
  end

  // req = {core_req, core_we, aux_req}; ctl = {core_gnt, aux_gnt, core_rvalid, aux_rvalid,
  // mem_en, mem_we}
  typedef struct {
    logic [2:0]  req;
    logic [23:0] caddr;
    logic [23:0] cwdata;
    logic [23:0] mrdata;
    logic [5:0]  ctl;
    logic [23:0] maddr;
    logic [23:0] mwdata;
    logic [23:0] crd;
    logic [23:0] ard;
    logic        busy;
  } vec_t;

  vec_t vecs[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    core_req = 1'b0;
    core_we = 1'b0;
    aux_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    core_req   = 1'b1;
    core_we    = 1'b0;
    core_addr  = 24'h000010;
    core_wdata = 24'h0;
    aux_req    = 1'b0;
    aux_we     = 1'b0;
    aux_addr   = 24'h000040;
    aux_wdata  = 24'h0;
    mem_rdata  = 24'h0;

    //          req     caddr      cwdata     mrdata     ctl        maddr      mwdata     crd        ard        busy
    vecs[0]  = '{3'b100, 24'h10, 24'h0,      24'h0,      6'b100010, 24'h10, 24'h0,      24'h0,      24'h0,      1'b0};
    vecs[1]  = '{3'b000, 24'h0,  24'h0,      24'h0,      6'b000000, 24'h0,  24'h0,      24'h0,      24'h0,      1'b1};
    vecs[2]  = '{3'b000, 24'h0,  24'h0,      24'hABCDEF, 6'b001000, 24'h0,  24'h0,      24'hABCDEF, 24'h0,      1'b1};
    vecs[3]  = '{3'b000, 24'h0,  24'h0,      24'hABCDEF, 6'b000000, 24'h0,  24'h0,      24'h0,      24'h0,      1'b0};
    vecs[4]  = '{3'b110, 24'h20, 24'h123456, 24'h0,      6'b100011, 24'h20, 24'h123456, 24'h0,      24'h0,      1'b0};
    vecs[5]  = '{3'b110, 24'h24, 24'h654321, 24'h0,      6'b100011, 24'h24, 24'h654321, 24'h0,      24'h0,      1'b0};
    vecs[6]  = '{3'b000, 24'h0,  24'h0,      24'hABCDEF, 6'b000000, 24'h0,  24'h0,      24'h0,      24'h0,      1'b0};
    vecs[7]  = '{3'b000, 24'h0,  24'h0,      24'hABCDEF, 6'b000000, 24'h0,  24'h0,      24'h0,      24'h0,      1'b0};
    vecs[8]  = '{3'b101, 24'h30, 24'h0,      24'h0,      6'b100010, 24'h30, 24'h0,      24'h0,      24'h0,      1'b0};
    vecs[9]  = '{3'b101, 24'h30, 24'h0,      24'h0,      6'b000000, 24'h0,  24'h0,      24'h0,      24'h0,      1'b1};
    vecs[10] = '{3'b101, 24'h30, 24'h0,      24'h111111, 6'b101010, 24'h30, 24'h0,      24'h111111, 24'h0,      1'b1};
    vecs[11] = '{3'b101, 24'h30, 24'h0,      24'h0,      6'b000000, 24'h0,  24'h0,      24'h0,      24'h0,      1'b1};
    vecs[12] = '{3'b101, 24'h30, 24'h0,      24'h222222, 6'b101010, 24'h30, 24'h0,      24'h222222, 24'h0,      1'b1};
    vecs[13] = '{3'b101, 24'h30, 24'h0,      24'h0,      6'b000000, 24'h0,  24'h0,      24'h0,      24'h0,      1'b1};
    vecs[14] = '{3'b101, 24'h30, 24'h0,      24'h333333, 6'b101010, 24'h30, 24'h0,      24'h333333, 24'h0,      1'b1};
    vecs[15] = '{3'b101, 24'h30, 24'h0,      24'h0,      6'b000000, 24'h0,  24'h0,      24'h0,      24'h0,      1'b1};
    vecs[16] = '{3'b101, 24'h30, 24'h0,      24'h444444, 6'b011010, 24'h40, 24'h0,      24'h444444, 24'h0,      1'b1};
    vecs[17] = '{3'b101, 24'h30, 24'h0,      24'h0,      6'b000000, 24'h0,  24'h0,      24'h0,      24'h0,      1'b1};
    vecs[18] = '{3'b101, 24'h30, 24'h0,      24'h555555, 6'b100110, 24'h30, 24'h0,      24'h0,      24'h555555, 1'b1};
    vecs[19] = '{3'b000, 24'h0,  24'h0,      24'h0,      6'b000000, 24'h0,  24'h0,      24'h0,      24'h0,      1'b1};
    vecs[20] = '{3'b000, 24'h0,  24'h0,      24'h666666, 6'b001000, 24'h0,  24'h0,      24'h666666, 24'h0,      1'b1};
    vecs[21] = '{3'b000, 24'h0,  24'h0,      24'h666666, 6'b000000, 24'h0,  24'h0,      24'h0,      24'h0,      1'b0};

    // Outputs stay quiet while reset is held, even with a request pending.
    @(negedge clk);
    #1;
    chk("rst_core_gnt", {31'b0, core_gnt[2]}, 32'd0);
    chk("rst_mem_en", {31'b0, mem_en[2]}, 32'd0);
    chk("rst_busy", {31'b0, busy[2]}, 32'd0);
    do_reset();

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      core_req   = vecs[i].req[2];
      core_we    = vecs[i].req[1];
      aux_req    = vecs[i].req[0];
      core_addr  = vecs[i].caddr;
      core_wdata = vecs[i].cwdata;
      mem_rdata  = vecs[i].mrdata;
      #1;
      chk($sformatf("v%0d_ctl", i),
          {26'b0, core_gnt[2], aux_gnt[2], core_rvalid[2], aux_rvalid[2], mem_en[2], mem_we[2]},
          {26'b0, vecs[i].ctl});
      chk($sformatf("v%0d_mem_addr", i), {8'b0, mem_addr[2]}, {8'b0, vecs[i].maddr});
      chk($sformatf("v%0d_mem_wdata", i), {8'b0, mem_wdata[2]}, {8'b0, vecs[i].mwdata});
      chk($sformatf("v%0d_core_rdata", i), {8'b0, core_rdata[2]}, {8'b0, vecs[i].crd});
      chk($sformatf("v%0d_aux_rdata", i), {8'b0, aux_rdata[2]}, {8'b0, vecs[i].ard});
      chk($sformatf("v%0d_busy", i), {31'b0, busy[2]}, {31'b0, vecs[i].busy});
    end

    // MEM_LAT=1: back-to-back reads stream one grant and one return per cycle.
    do_reset();
    @(negedge clk);
    core_req = 1'b1; core_we = 1'b0; core_addr = 24'h000100; mem_rdata = 24'h0;
    #1;
    chk("l1_t0_gnt", {31'b0, core_gnt[1]}, 32'd1);
    chk("l1_t0_addr", {8'b0, mem_addr[1]}, 32'h100);
    chk("l1_t0_rvalid", {31'b0, core_rvalid[1]}, 32'd0);
    @(negedge clk);
    core_addr = 24'h000104; mem_rdata = 24'hAAAAAA;
    #1;
    chk("l1_t1_gnt", {31'b0, core_gnt[1]}, 32'd1);
    chk("l1_t1_addr", {8'b0, mem_addr[1]}, 32'h104);
    chk("l1_t1_rvalid", {31'b0, core_rvalid[1]}, 32'd1);
    chk("l1_t1_rdata", {8'b0, core_rdata[1]}, 32'hAAAAAA);
    @(negedge clk);
    core_req = 1'b0; mem_rdata = 24'hBBBBBB;
    #1;
    chk("l1_t2_gnt", {31'b0, core_gnt[1]}, 32'd0);
    chk("l1_t2_rvalid", {31'b0, core_rvalid[1]}, 32'd1);
    chk("l1_t2_rdata", {8'b0, core_rdata[1]}, 32'hBBBBBB);
    @(negedge clk);
    mem_rdata = 24'hCCCCCC;
    #1;
    chk("l1_t3_rvalid", {31'b0, core_rvalid[1]}, 32'd0);
    chk("l1_t3_busy", {31'b0, busy[1]}, 32'd0);

    // MEM_LAT=3: reset one cycle after an aux read issue drops that read entirely.
    do_reset();
    @(negedge clk);
    aux_req = 1'b1; core_req = 1'b0; mem_rdata = 24'h0;
    #1;
    chk("l3_t0_aux_gnt", {31'b0, aux_gnt[3]}, 32'd1);
    @(negedge clk);
    rst = 1'b1; aux_req = 1'b0;
    #1;
    chk("l3_t1_busy", {31'b0, busy[3]}, 32'd0);
    chk("l3_t1_aux_gnt", {31'b0, aux_gnt[3]}, 32'd0);
    @(negedge clk);
    rst = 1'b0; core_req = 1'b1; core_addr = 24'h000060;
    #1;
    chk("l3_t2_core_gnt", {31'b0, core_gnt[3]}, 32'd1);
    chk("l3_t2_busy", {31'b0, busy[3]}, 32'd0);
    @(negedge clk);
    core_req = 1'b0; mem_rdata = 24'hDDDDDD;
    #1;
    chk("l3_t3_aux_rvalid", {31'b0, aux_rvalid[3]}, 32'd0);
    chk("l3_t3_core_rvalid", {31'b0, core_rvalid[3]}, 32'd0);
    chk("l3_t3_busy", {31'b0, busy[3]}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between the pipeline MEM stage (core) and a secondary auxiliary requester (debug/DMA).
- Sequences each access to the memory's fixed read latency and routes read data back to the requester that owns it.
- Core has priority, bounded by a starvation limit so aux always progresses.
- Core stalls while its request is pending without a grant; this replaces fixed-count memory stalls with grant-driven stalls.

Parameters:
- ADDR_W, 24, memory address width
- DATA_W, 24, memory data width
- MEM_LAT, 2, cycles from issue to valid iw_mem_rdata (legal 1..7)
- STARVE_MAX, 4, consecutive core grants allowed while aux waits (legal 1..15)

Ports:
- iw_clk  in  1  clock; all logic on rising edge
- iw_rst  in  1  synchronous, active-high reset
- iw_core_req  in  1  core access request
- iw_core_we  in  1  1=store, 0=load
- iw_core_addr  in  ADDR_W  core address
- iw_core_wdata  in  DATA_W  core store data
- ow_core_gnt  out  1  core request accepted this cycle
- ow_core_rvalid  out  1  core load data valid (1 cycle)
- ow_core_rdata  out  DATA_W  core load data
- iw_aux_req, iw_aux_we, iw_aux_addr, iw_aux_wdata  in  1/1/ADDR_W/DATA_W  aux equivalents
- ow_aux_gnt, ow_aux_rvalid, ow_aux_rdata  out  1/1/DATA_W  aux equivalents
- ow_mem_en  out  1  memory access strobe
- ow_mem_we  out  1  memory write enable
- ow_mem_addr  out  ADDR_W  memory address
- ow_mem_wdata  out  DATA_W  memory write data
- iw_mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after read issue
- ow_busy  out  1  a read is in flight

Behaviour:
- Handshake: a requester holds req/we/addr/wdata stable until it sees gnt high. The grant cycle is the issue cycle. gnt and ow_mem_* are combinational from the selected requester in that cycle. Req may remain high after gnt to request the next access back-to-back.
- State:
  - 3-bit latency counter r_cnt.
  - owner bit r_own (0=core, 1=aux).
  - 4-bit starvation counter r_starve.
- Grant eligibility: r_cnt == 0 or r_cnt == 1. A new issue is allowed in the same cycle as returning read data, which gives full throughput at MEM_LAT=1.
- Selection when eligible:
  - Aux wins if aux_req && (!core_req || r_starve == STARVE_MAX).
  - Otherwise core wins if core_req.
  - Exactly one gnt at most per cycle.
- Read grant: r_cnt <= MEM_LAT and r_own <= winner.
- Write grant: r_cnt is unchanged by the issue (it keeps decrementing if nonzero). Writes never produce rvalid.
- r_cnt decrements each cycle while nonzero, unless reloaded by a read grant.
- rvalid: when r_cnt == 1, assert the rvalid of r_own for one cycle. The matching rdata output equals iw_mem_rdata. The non-owner rdata is 0.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) on a core grant while aux_req is high.
  - Clears on an aux grant or whenever aux_req is low.
- ow_mem_en = any gnt. When no gnt, ow_mem_we/addr/wdata are 0.
- ow_busy = (r_cnt != 0).
- Reset: r_cnt=0, r_own=0, r_starve=0. All gnt, rvalid, ow_mem_en and ow_busy outputs are 0 during any cycle with iw_rst high (combinational outputs are gated by iw_rst). A read in flight at reset is discarded and its rvalid never appears.
- Simultaneous events:
  - Both req at r_starve<STARVE_MAX: core wins.
  - rvalid cycle plus new request: both occur. The new read reloads r_cnt to MEM_LAT.
- Unused high address bits need no special handling; the full ADDR_W is forwarded.

Decomposition:
- Shared package/header holds:
  - OWN_CORE=1'b0 and OWN_AUX=1'b1
  - default widths taken from the existing size macros
- Natural sub-module: dmem_arb_select. It is combinational winner selection plus the r_starve register. The latency counter and routing stay in dmem_arbiter.

Test Plan:
- MEM_LAT=2, core read addr 0x000010, memory returns 0xABCDEF → core_gnt at T0; core_rvalid=1 and core_rdata=0xABCDEF at T2 only; aux_rvalid stays 0.
- Core read held continuously, aux read pending, STARVE_MAX=4 → 4 core grants, then aux_gnt on the 5th grant slot; r_starve returns to 0.
- Core write (we=1, addr 0x20, wdata 0x123456) → ow_mem_en=1, ow_mem_we=1 and addr/wdata matching in the grant cycle; no rvalid at any later cycle; next core request granted the following cycle.
- MEM_LAT=1, back-to-back core reads A then B → gnt every cycle; rvalid every cycle starting T1; data order A, B.
- Aux read granted at T0 (MEM_LAT=3), iw_rst high at T1 → no aux_rvalid at T3; ow_busy=0 from T1; new core read granted at T2.
- Both req in the rvalid cycle of a prior aux read → core_gnt in that same cycle; aux_rvalid still asserted in that cycle.
